// File: rtl/card_shoe.sv
// Single-deck card shoe: LFSR-driven Fisher-Yates shuffle of a 52-entry deck,
// then one card dealt per accepted draw request, with reshuffle status.
module card_shoe #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          RESHUFFLE_AT = 12
) (
  input  logic       CLOCK_50_i,
  input  logic       reset_i,
  input  logic       draw_req_i,
  input  logic       shuffle_req_i,
  output logic       card_valid_o,
  output logic [3:0] card_value_o,
  output logic [3:0] card_rank_o,
  output logic [5:0] cards_left_o,
  output logic       ready_o,
  output logic       shuffling_o,
  output logic       needs_shuffle_o
);

  typedef enum logic [2:0] {S_RST, S_INIT, S_PICK, S_SWAP, S_READY, S_EMPTY} state_t;

  localparam logic [5:0] RESHUF_LIMIT = RESHUFFLE_AT[5:0];

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [5:0]  k_q, k_d, i_q, i_d, j_q, j_d, ptr_q, ptr_d, left_q, left_d;
  logic        valid_q, valid_d, ready_q, ready_d, shuffling_q, shuffling_d, needs_q, needs_d;
  logic [3:0]  value_q, value_d, rank_q, rank_d;
  logic [5:0]  deck_q [52];
  logic [5:0]  cand, deal_idx;

  // Smallest all-ones mask covering i, i.e. 2^ceil(log2(i+1))-1.
  function automatic logic [5:0] smear(input logic [5:0] v);
    return v | (v >> 1) | (v >> 2) | (v >> 3) | (v >> 4) | (v >> 5);
  endfunction

  // idx mod 13 + 1 done in 4-bit arithmetic: each suit band adds a fixed offset mod 16.
  function automatic logic [3:0] rank_of(input logic [5:0] idx);
    logic [3:0] off;
    if (idx < 6'd13)      off = 4'd1;
    else if (idx < 6'd26) off = 4'd4;
    else if (idx < 6'd39) off = 4'd7;
    else                  off = 4'd10;
    return idx[3:0] + off;
  endfunction

  function automatic logic [3:0] value_of(input logic [3:0] r);
    if (r == 4'd1)       return 4'd11;
    else if (r >= 4'd11) return 4'd10;
    else                 return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    ptr_d    = ptr_q;
    left_d   = left_q;
    valid_d  = 1'b0;
    value_d  = value_q;
    rank_d   = rank_q;
    cand     = lfsr_q[5:0] & smear(i_q);
    deal_idx = (ptr_q < 6'd52) ? deck_q[ptr_q] : 6'd0;
    case (state_q)
      S_RST: begin
        state_d = S_INIT;
        k_d     = 6'd0;
      end
      S_INIT: begin
        k_d = k_q + 6'd1;
        if (k_q == 6'd51) begin
          i_d     = 6'd51;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (cand <= i_q) begin
          j_d     = cand;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        i_d = i_q - 6'd1;
        if (i_q == 6'd1) begin
          ptr_d   = 6'd0;
          left_d  = 6'd52;
          state_d = S_READY;
        end else begin
          state_d = S_PICK;
        end
      end
      S_READY: begin
        if (shuffle_req_i) begin
          state_d = S_INIT;
          k_d     = 6'd0;
        end else if (draw_req_i) begin
          valid_d = 1'b1;
          rank_d  = rank_of(deal_idx);
          value_d = value_of(rank_of(deal_idx));
          ptr_d   = ptr_q + 6'd1;
          left_d  = left_q - 6'd1;
          if (left_q == 6'd1) state_d = S_EMPTY;
        end
      end
      S_EMPTY: begin
        if (shuffle_req_i) begin
          state_d = S_INIT;
          k_d     = 6'd0;
        end
      end
      default: state_d = S_RST;
    endcase
    // Status is derived from the next state so every flag changes on the same edge as the state.
    ready_d     = (state_d == S_READY);
    shuffling_d = (state_d == S_INIT) || (state_d == S_PICK) || (state_d == S_SWAP);
    needs_d     = ((state_d == S_READY) || (state_d == S_EMPTY)) && (left_d < RESHUF_LIMIT);
  end

  always_ff @(posedge CLOCK_50_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_RST;
      lfsr_q      <= LFSR_SEED;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      ptr_q       <= '0;
      left_q      <= '0;
      valid_q     <= 1'b0;
      value_q     <= '0;
      rank_q      <= '0;
      ready_q     <= 1'b0;
      shuffling_q <= 1'b0;
      needs_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
      rank_q      <= rank_d;
      ready_q     <= ready_d;
      shuffling_q <= shuffling_d;
      needs_q     <= needs_d;
    end
  end

  // Deck contents need no reset: every rebuild starts by rewriting all 52 entries.
  always_ff @(posedge CLOCK_50_i) begin
    if (state_q == S_INIT) begin
      deck_q[k_q] <= k_q;
    end else if (state_q == S_SWAP) begin
      deck_q[i_q] <= deck_q[j_q];
      deck_q[j_q] <= deck_q[i_q];
    end
  end

  assign card_valid_o    = valid_q;
  assign card_value_o    = value_q;
  assign card_rank_o     = rank_q;
  assign cards_left_o    = left_q;
  assign ready_o         = ready_q;
  assign shuffling_o     = shuffling_q;
  assign needs_shuffle_o = needs_q;

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: behavioural deal model with a scoreboard of expected deals,
// a vector table for the first draws, and hand sequences for shuffle/reset corners.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst;
  logic       draw_req, shuffle_req;
  logic       card_valid_o;
  logic [3:0] card_value_o, card_rank_o;
  logic [5:0] cards_left_o;
  logic       ready_o, shuffling_o, needs_shuffle_o;

  card_shoe #(.LFSR_SEED(16'hACE1), .RESHUFFLE_AT(12)) dut (
    .CLOCK_50_i     (clk),
    .reset_i        (rst),
    .draw_req_i     (draw_req),
    .shuffle_req_i  (shuffle_req),
    .card_valid_o   (card_valid_o),
    .card_value_o   (card_value_o),
    .card_rank_o    (card_rank_o),
    .cards_left_o   (cards_left_o),
    .ready_o        (ready_o),
    .shuffling_o    (shuffling_o),
    .needs_shuffle_o(needs_shuffle_o)
  );

  always #10 clk = ~clk;

  typedef enum {M_BUSY, M_READY, M_EMPTY} mst_t;
  typedef struct { logic d; logic s; logic exp_valid; int exp_left; } vec_t;

  int   checks = 0, passes = 0;
  mst_t m_st = M_BUSY;
  int   m_left = 0;
  int   sb[$];
  int   strobes = 0;
  int   rank_cnt[14];
  int   last_rank = 0;
  int   seq_cur[52], seq_a[52];
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_value(input int r);
    if (r == 1) return 11;
    if (r >= 11) return 10;
    return r;
  endfunction

  task automatic clear_counts();
    for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
    strobes = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, card_valid_o, 0);
    check({tag, "_value"}, card_value_o, 0);
    check({tag, "_rank"}, card_rank_o, 0);
    check({tag, "_left"}, cards_left_o, 0);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_shuffling"}, shuffling_o, 0);
    check({tag, "_needs"}, needs_shuffle_o, 0);
  endtask

  // One clock of stimulus; the model decides whether a deal is expected.
  task automatic step(input logic d, input logic s);
    int e;
    @(negedge clk);
    draw_req = d;
    shuffle_req = s;
    if (m_st == M_READY && s) m_st = M_BUSY;
    else if (m_st == M_READY && d) begin
      m_left--;
      sb.push_back(m_left);
      if (m_left == 0) m_st = M_EMPTY;
    end else if (m_st == M_EMPTY && s) m_st = M_BUSY;
    @(posedge clk);
    #1;
    draw_req = 1'b0;
    shuffle_req = 1'b0;
    if (card_valid_o) begin
      strobes++;
      if (sb.size() == 0) check("unexpected_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        check("deal_cards_left", cards_left_o, e);
        check("value_map", card_value_o, exp_value(card_rank_o));
        last_rank = card_rank_o;
        if (card_rank_o >= 1 && card_rank_o <= 13) rank_cnt[card_rank_o]++;
        else check("rank_range", card_rank_o, 1);
        if (e == 11) check("needs_at_11", needs_shuffle_o, 1);
      end
    end else if (sb.size() != 0) begin
      check("missing_strobe", 0, 1);
      sb.delete();
    end
    check("ready", ready_o, m_st == M_READY);
    check("shuffling", shuffling_o, m_st == M_BUSY);
    if (m_st != M_BUSY) begin
      check("cards_left", cards_left_o, m_left);
      check("needs_shuffle", needs_shuffle_o, m_left < 12);
    end else begin
      check("needs_shuffle_busy", needs_shuffle_o, 0);
    end
  endtask

  task automatic wait_ready(output int cyc);
    int spurious;
    spurious = 0;
    cyc = 0;
    while (!ready_o && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (card_valid_o) spurious++;
    end
    check("ready_within_budget", ready_o, 1);
    check("no_strobe_while_shuffling", spurious, 0);
    check("left_at_ready", cards_left_o, 52);
    check("shuffling_at_ready", shuffling_o, 0);
    check("needs_at_ready", needs_shuffle_o, 0);
    m_st = ready_o ? M_READY : M_BUSY;
    m_left = 52;
  endtask

  task automatic check_rank_counts(input string tag);
    check({tag, "_strobes"}, strobes, 52);
    for (int r = 1; r <= 13; r++) check($sformatf("%s_rank%0d_count", tag, r), rank_cnt[r], 4);
  endtask

  task automatic deal_pass(input string tag);
    clear_counts();
    for (int n = 0; n < 52; n++) begin
      step(1'b1, 1'b0);
      seq_cur[n] = card_rank_o;
    end
    check_rank_counts(tag);
  endtask

  // Reset with fixed timing, pulse reset again in the middle of the shuffle, deal a full deck.
  task automatic seeded_run();
    int c;
    @(negedge clk);
    rst = 1'b1;
    m_st = M_BUSY;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b0;
    wait_ready(c);
    deal_pass("seeded");
  endtask

  initial begin
    int c, mism, guard;
    rst = 1'b1;
    draw_req = 1'b0;
    shuffle_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_shuffling", shuffling_o, 1);
    check("first_edge_ready", ready_o, 0);
    wait_ready(c);
    check("init_cycles_ge_155", (c + 1) >= 155, 1);

    vecs[0] = '{1'b0, 1'b0, 1'b0, 52};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 51};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 50};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 50};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 49};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 49};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 48};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 47};
    clear_counts();
    for (int v = 0; v < 8; v++) begin
      step(vecs[v].d, vecs[v].s);
      check($sformatf("vec%0d_valid", v), card_valid_o, vecs[v].exp_valid);
      check($sformatf("vec%0d_left", v), cards_left_o, vecs[v].exp_left);
    end
    guard = 0;
    while (m_st == M_READY && guard < 60) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check_rank_counts("pass1");
    check("empty_ready", ready_o, 0);
    check("empty_left", cards_left_o, 0);

    step(1'b1, 1'b0);
    check("draw53_no_strobe", card_valid_o, 0);
    check("rank_held", card_rank_o, last_rank);

    step(1'b0, 1'b1);
    wait_ready(c);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0);
    check("left_after_20", cards_left_o, 32);
    step(1'b0, 1'b1);
    check("shuffle_drops_ready", ready_o, 0);
    wait_ready(c);

    step(1'b1, 1'b1);
    check("both_req_no_strobe", card_valid_o, 0);
    check("both_req_left", cards_left_o, 52);
    check("both_req_shuffling", shuffling_o, 1);
    wait_ready(c);
    deal_pass("pass_after_shuffle");

    seeded_run();
    seq_a = seq_cur;
    seeded_run();
    mism = 0;
    for (int n = 0; n < 52; n++) if (seq_a[n] != seq_cur[n]) mism++;
    check("seed_determinism_mismatches", mism, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Single-deck card shoe that replaces free-running random card generation with draw-without-replacement. It holds a 52-entry deck, shuffles it in place with an LFSR-driven Fisher-Yates pass, and deals one card per accepted draw request. It sits directly upstream of blackjack_fsm and supplies its 4-bit card value, plus status for reshuffle decisions.

## Interface
- LFSR_SEED, 16'hACE1: LFSR load value on reset; must be nonzero.
- RESHUFFLE_AT, 12: needs_shuffle asserts when cards_left < RESHUFFLE_AT.
- CLOCK_50  in  1  system clock, all state on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- draw_req  in  1  single-cycle request for one card (debounced pulse).
- shuffle_req  in  1  single-cycle request to rebuild and reshuffle the deck.
- card_valid  out  1  one-cycle strobe; card_value/card_rank are valid.
- card_value  out  4  blackjack value: ace=11, 2..10 face value, J/Q/K=10.
- card_rank  out  4  rank 1..13 (1=ace, 11=J, 12=Q, 13=K).
- cards_left  out  6  undealt cards, 0..52.
- ready  out  1  deck shuffled and cards_left>0; draws accepted.
- shuffling  out  1  high in INIT/PICK/SWAP.
- needs_shuffle  out  1  cards_left < RESHUFFLE_AT while in READY or EMPTY.

## Operation
- Storage: deck[0..51], 6-bit card index each; rank = index mod 13 + 1. Index is a register array, so a swap completes in one cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state. Loaded with LFSR_SEED on reset.
- States:
  - RST: reset state. Unconditional exit to INIT.
  - INIT: writes deck[k]=k, k=0..51, one entry per cycle. Then sets i=51 and enters PICK.
  - PICK: cand = lfsr[5:0] & mask(i), where mask(i) = 2^ceil(log2(i+1))-1.
    - If cand <= i: j=cand, enter SWAP.
    - Otherwise stay in PICK (rejection).
  - SWAP: exchange deck[i] and deck[j], then i=i-1.
    - If the old i was 1: ptr=0, cards_left=52, enter READY.
    - Otherwise enter PICK.
  - READY: on draw_req, deals deck[ptr], sets ptr=ptr+1 and cards_left=cards_left-1. If cards_left reaches 0, enter EMPTY.
  - EMPTY: ready=0. draw_req is ignored.
- shuffle_req in READY or EMPTY enters INIT. shuffle_req in INIT/PICK/SWAP is ignored.
- If shuffle_req and draw_req arrive in the same READY cycle, shuffle wins: no card is dealt, cards_left is unchanged, and the next state is INIT.
- draw_req outside READY is dropped and not queued.
- Value mapping: rank 1 -> 11; rank 2..10 -> rank; rank 11..13 -> 10.

## Timing
- Reset values, applied asynchronously: card_valid=0, card_value=0, card_rank=0, cards_left=0, ready=0, shuffling=0, needs_shuffle=0; state=RST; ptr=0.
- All outputs are registered.
- First edge after reset deasserts: RST->INIT; shuffling=1 from that edge.
- INIT lasts 52 cycles. Each of the 51 swaps costs (PICK cycles >= 1) + 1 SWAP cycle, so the minimum INIT-to-READY time is 52+102 = 154 cycles.
- Draw latency: draw_req high at edge k in READY gives, at edge k:
  - card_valid=1 for exactly one cycle;
  - card_value and card_rank updated and held until the next deal or reset;
  - cards_left decremented.
- Back-to-back draws: one card per cycle.
- ready falls at the same edge that deals the 52nd card.
- ready and needs_shuffle fall at the edge that enters INIT.
- Reset mid-shuffle or mid-deal: immediate return to reset values, and a full rebuild restarts from RST.

## Test plan
- Reset, then wait for ready=1 → shuffling=0, cards_left=52, needs_shuffle=0, card_valid never asserted. Elapsed cycles >= 155.
- 52 single draws → exactly 52 card_valid strobes; each rank 1..13 seen exactly 4 times; card_value consistent with mapping (rank 1→11, 12→10, 7→7). After the last draw: ready=0, cards_left=0, state EMPTY. A 53rd draw_req → no strobe.
- Draw count crossing: at cards_left=11 with RESHUFFLE_AT=12 → needs_shuffle=1 at the same edge.
- shuffle_req after 20 draws → ready=0 next edge and the deck is rebuilt. Then cards_left=52 and a full 52-draw pass shows 4 of each rank again.
- shuffle_req and draw_req in the same READY cycle → no card_valid, cards_left unchanged, shuffling=1.
- Assert reset during PICK and deal two full decks with identical stimulus timing each time → identical 52-card sequences both times (seed determinism). All outputs go to reset values while reset is high, without waiting for a clock.
